cla4_result_checker: RTL and testbench

Synthesizable response checker for the carry-lookahead adder datapath. It sits on the output side of an adder under test and consumes operand/result tuples {A, B, C_in, SUM, C_out} through a valid/ready handshake. It recomputes the golden sum in a two-stage pipeline, counts samples and mismatches, and reports pass/fail at the end of a run. It pairs with the operand-driving stimulus so that adder regressions, on simulation or FPGA, no longer depend on reading a $monitor log.

---
 rtl/cla4_result_checker_pkg.sv | 14 +
 rtl/cla4_result_checker_sat_counter.sv | 30 +++
 rtl/cla4_result_checker.sv | 166 ++++++++++++++++
 tb/tb_cla4_result_checker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla4_result_checker_pkg.sv
// Shared types and default sizes for the CLA adder result checker.
package cla4_result_checker_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_REPORT
  } state_e;

endpackage

// File: rtl/cla4_result_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cla4_result_checker.sv
// Two-stage golden-sum checker for an adder under test; counts samples/mismatches and reports per run.
// Optional first-failure capture is built when CLA_CHK_FIRST_FAIL_EN is defined.
module cla4_result_checker
  import cla4_result_checker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             last,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [WIDTH-1:0] sum,
  input  logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic             ff_cin,
  output logic [WIDTH:0]   ff_got
);

  state_e state_q, state_d;

  logic             accept;
  logic             clr;
  logic             s1_vld_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s1_cin_q;
  logic [WIDTH:0]   s1_got_q;
  logic [WIDTH:0]   exp_sum;
  logic             s2_vld_q, s2_err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_RUN;
      ST_RUN:    if (last)  state_d = ST_DRAIN;
      ST_DRAIN:  if (!s1_vld_q && !s2_vld_q) state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign in_ready = (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;
  assign clr      = start && (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_cin_q <= 1'b0;
      s1_got_q <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_a_q   <= a;
        s1_b_q   <= b;
        s1_cin_q <= c_in;
        s1_got_q <= {c_out, sum};
      end
    end
  end

  // Full WIDTH+1 result so a dropped carry-out is caught as a mismatch.
  assign exp_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, s1_cin_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      s2_err_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      s2_err_q <= s1_vld_q && (exp_sum != s1_got_q);
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_smp_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (s2_vld_q),
    .cnt (smp_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (s2_vld_q && s2_err_q),
    .cnt (err_cnt)
  );

`ifdef CLA_CHK_FIRST_FAIL_EN
  logic [WIDTH-1:0] s2_a_q, s2_b_q, ff_a_q, ff_b_q;
  logic             s2_cin_q, ff_cin_q;
  logic [WIDTH:0]   s2_got_q, ff_got_q;
  logic             ff_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_a_q   <= '0;
      s2_b_q   <= '0;
      s2_cin_q <= 1'b0;
      s2_got_q <= '0;
    end else if (s1_vld_q) begin
      s2_a_q   <= s1_a_q;
      s2_b_q   <= s1_b_q;
      s2_cin_q <= s1_cin_q;
      s2_got_q <= s1_got_q;
    end
  end

  // Loads on the same edge err_cnt leaves zero.
  assign ff_load = s2_vld_q && s2_err_q && (err_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_a_q   <= '0;
      ff_b_q   <= '0;
      ff_cin_q <= 1'b0;
      ff_got_q <= '0;
    end else if (clr) begin
      ff_a_q   <= '0;
      ff_b_q   <= '0;
      ff_cin_q <= 1'b0;
      ff_got_q <= '0;
    end else if (ff_load) begin
      ff_a_q   <= s2_a_q;
      ff_b_q   <= s2_b_q;
      ff_cin_q <= s2_cin_q;
      ff_got_q <= s2_got_q;
    end
  end

  assign ff_a   = ff_a_q;
  assign ff_b   = ff_b_q;
  assign ff_cin = ff_cin_q;
  assign ff_got = ff_got_q;
`else
  assign ff_a   = '0;
  assign ff_b   = '0;
  assign ff_cin = 1'b0;
  assign ff_got = '0;
`endif

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_REPORT);
  assign pass = done && (err_cnt == '0) && (smp_cnt != '0);

endmodule

// File: tb/tb_cla4_result_checker.sv
// Scoreboard bench: stimulus pushes expected run reports, a negedge monitor pops and checks them on done.
module tb_cla4_result_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, last = 1'b0, in_valid = 1'b0;
  logic [3:0] a = '0, b = '0, sum = '0;
  logic c_in = 1'b0, c_out = 1'b0;

  logic        in_ready, busy, done, pass;
  logic [15:0] smp_cnt, err_cnt;
  logic [3:0]  ff_a, ff_b;
  logic        ff_cin;
  logic [4:0]  ff_got;

  logic        in_ready2, busy2, done2, pass2;
  logic [1:0]  smp_cnt2, err_cnt2;
  logic [3:0]  ff_a2, ff_b2;
  logic        ff_cin2;
  logic [4:0]  ff_got2;

  cla4_result_checker #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .last(last), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .c_in(c_in), .sum(sum), .c_out(c_out),
    .busy(busy), .done(done), .pass(pass), .smp_cnt(smp_cnt), .err_cnt(err_cnt),
    .ff_a(ff_a), .ff_b(ff_b), .ff_cin(ff_cin), .ff_got(ff_got)
  );

  cla4_result_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .last(last), .in_valid(in_valid),
    .in_ready(in_ready2), .a(a), .b(b), .c_in(c_in), .sum(sum), .c_out(c_out),
    .busy(busy2), .done(done2), .pass(pass2), .smp_cnt(smp_cnt2), .err_cnt(err_cnt2),
    .ff_a(ff_a2), .ff_b(ff_b2), .ff_cin(ff_cin2), .ff_got(ff_got2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  typedef struct {
    int         smp, err, smp2, err2;
    bit         pass;
    logic [3:0] fa, fb;
    logic       fc;
    logic [4:0] fg;
    int         last_cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model for the current run.
  int         m_n, m_e;
  bit         m_hasff;
  logic [3:0] m_fa, m_fb;
  logic       m_fc;
  logic [4:0] m_fg;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    m_n = 0; m_e = 0; m_hasff = 0;
    m_fa = '0; m_fb = '0; m_fc = 1'b0; m_fg = '0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.smp  = sat(m_n, 65535);
    e.err  = sat(m_e, 65535);
    e.smp2 = sat(m_n, 3);
    e.err2 = sat(m_e, 3);
    e.pass = (m_e == 0) && (m_n != 0);
`ifdef CLA_CHK_FIRST_FAIL_EN
    e.fa = m_fa; e.fb = m_fb; e.fc = m_fc; e.fg = m_fg;
`else
    e.fa = '0; e.fb = '0; e.fc = 1'b0; e.fg = '0;
`endif
    e.last_cyc = cyc;
    exp_q.push_back(e);
  endtask

  // All tasks start and end at posedge+1.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic [3:0] pa, input logic [3:0] pb, input logic pc,
                      input logic [4:0] pgot, input bit is_last);
    a = pa; b = pb; c_in = pc; sum = pgot[3:0]; c_out = pgot[4];
    in_valid = 1'b1; last = is_last;
    @(negedge clk);
    chk("in_ready_run", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; last = 1'b0;
    m_n++;
    if (int'(pgot) != int'(pa) + int'(pb) + int'(pc)) begin
      m_e++;
      if (!m_hasff) begin
        m_hasff = 1; m_fa = pa; m_fb = pb; m_fc = pc; m_fg = pgot;
      end
    end
    if (is_last) push_exp();
  endtask

  task automatic end_run();
    last = 1'b1;
    @(posedge clk); #1;
    last = 1'b0;
    push_exp();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("report_timeout_pending", exp_q.size(), 0);
    idle(1);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("smp_cnt", smp_cnt, e.smp);
        chk("err_cnt", err_cnt, e.err);
        chk("pass", pass, e.pass);
        chk("busy_with_done", busy, 1);
        chk("smp_cnt_sat2", smp_cnt2, e.smp2);
        chk("err_cnt_sat2", err_cnt2, e.err2);
        chk("done2_aligned", done2, 1);
        chk("ff_a", ff_a, e.fa);
        chk("ff_b", ff_b, e.fb);
        chk("ff_cin", ff_cin, e.fc);
        chk("ff_got", ff_got, e.fg);
        chk("done_latency_le3", (cyc - e.last_cyc) <= 3, 1);
      end
    end
  end

  // done must be a single-cycle pulse.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst && done && prev_done) chk("done_one_cycle", 1, 0);
    prev_done <= done;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ra, rb;
    logic       rc;
    logic [4:0] rg;
    int         n;
    bit         lst;

    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_smp_cnt", smp_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_ff_got", ff_got, 0);
    rst = 1'b0;
    idle(1);

    // last outside RUN is ignored
    last = 1'b1; idle(1); last = 1'b0;
    chk("last_in_idle_busy", busy, 0);

    // Directed clean run
    do_start();
    chk("after_start_smp", smp_cnt, 0);
    send(4'd7, 4'd3, 1'b0, 5'b01010, 0);
    send(4'd8, 4'd4, 1'b0, 5'b01100, 0);
    send(4'd10, 4'd5, 1'b0, 5'b01111, 0);
    end_run();
    wait_done();

    // Carry-out case, then the same operands with carry dropped
    do_start();
    send(4'd15, 4'd1, 1'b0, 5'b10000, 0);
    send(4'd15, 4'd1, 1'b0, 5'b00000, 0);
    end_run();
    wait_done();

    // Faulty sum arriving together with last
    do_start();
    send(4'd7, 4'd3, 1'b0, 5'b01011, 1);
    wait_done();

    // Saturation of the narrow instance: 5 good then 5 bad
    do_start();
    for (int i = 0; i < 5; i++) send(4'(i), 4'd2, 1'b1, 5'(i + 3), 0);
    for (int i = 0; i < 5; i++) send(4'(i), 4'd2, 1'b0, 5'(i + 9), 0);
    end_run();
    wait_done();

    // start+last together in IDLE: start wins; start in RUN does not clear
    start = 1'b1; last = 1'b1;
    idle(1);
    start = 1'b0; last = 1'b0;
    model_clear();
    chk("start_last_in_ready", in_ready, 1);
    send(4'd1, 4'd1, 1'b1, 5'd3, 0);
    idle(3);
    start = 1'b1; idle(1); start = 1'b0;
    chk("start_in_run_ignored", smp_cnt, 1);
    send(4'd2, 4'd2, 1'b0, 5'd4, 0);
    end_run();
    wait_done();

    // Reset mid-run with samples in flight
    do_start();
    send(4'd1, 4'd2, 1'b0, 5'd3, 0);
    send(4'd3, 4'd4, 1'b0, 5'd7, 0);
    send(4'd5, 4'd6, 1'b0, 5'd11, 0);
    chk("pre_rst_smp_cnt", smp_cnt, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_smp_cnt", smp_cnt, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    do_start();
    send(4'd9, 4'd9, 1'b1, 5'd19, 0);
    send(4'd9, 4'd9, 1'b1, 5'd18, 0);
    end_run();
    wait_done();

    // Randomised runs, including empty runs and last on a sample
    for (int r = 0; r < 16; r++) begin
      do_start();
      n = $urandom_range(0, 7);
      lst = 0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        ra = 4'($urandom_range(0, 15));
        rb = 4'($urandom_range(0, 15));
        rc = 1'($urandom_range(0, 1));
        rg = 5'(int'(ra) + int'(rb) + int'(rc));
        if ($urandom_range(0, 3) == 0) rg = rg ^ 5'(1 << $urandom_range(0, 4));
        lst = (i == n - 1) && ($urandom_range(0, 1) == 1);
        send(ra, rb, rc, rg, lst);
      end
      if (!lst) end_run();
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
